// File: rtl/cla_serial_pkg.sv
// Shared types and width helpers for the word-serial carry-lookahead adder.
// The state encoding and index width are used by the controller.
package cla_serial_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Word index needs at least one bit even when only one word exists.
  function automatic int idx_width(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/cla_serial_add_ctrl_if.sv
// Request/result handshake bundle between a requester and the serial adder.
// master drives operands and result acceptance; slave is the adder controller.
interface cla_serial_add_ctrl_if #(
  parameter int W  = 8,
  parameter int NW = 4
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [W*NW-1:0] a_i;
  logic [W*NW-1:0] b_i;
  logic            cin_i;
  logic            sub_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [W*NW-1:0] sum_o;
  logic            cout_o;
  logic            ovf_o;
  logic            busy_o;

  modport master (
    output in_valid_i, a_i, b_i, cin_i, sub_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o, cout_o, ovf_o, busy_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, cin_i, sub_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o, cout_o, ovf_o, busy_o
  );
endinterface

// File: rtl/cla_word_adder.sv
// Combinational W-bit carry-lookahead adder built from 4-bit lookahead groups
// with a second lookahead level across the group generate/propagate signals.
module cla_word_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);
  localparam int NG = W / 4;

  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W-1:0]  c;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG:0]   gc;

  assign g = a & b;
  assign p = a ^ b;

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      localparam int LSB = 4 * gi;
      assign gg[gi] = g[LSB+3] | (p[LSB+3] & g[LSB+2]) | (p[LSB+3] & p[LSB+2] & g[LSB+1])
                    | (p[LSB+3] & p[LSB+2] & p[LSB+1] & g[LSB]);
      assign gp[gi] = &p[LSB+3:LSB];
      assign c[LSB]   = gc[gi];
      assign c[LSB+1] = g[LSB] | (p[LSB] & gc[gi]);
      assign c[LSB+2] = g[LSB+1] | (p[LSB+1] & g[LSB]) | (p[LSB+1] & p[LSB] & gc[gi]);
      assign c[LSB+3] = g[LSB+2] | (p[LSB+2] & g[LSB+1]) | (p[LSB+2] & p[LSB+1] & g[LSB])
                      | (p[LSB+2] & p[LSB+1] & p[LSB] & gc[gi]);
    end
  endgenerate

  // Group carries as flat sum-of-products over group G/P, not a chain.
  always_comb begin
    logic terms;
    logic prop;
    gc    = '0;
    gc[0] = cin;
    for (int k = 1; k <= NG; k++) begin
      terms = 1'b0;
      prop  = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        terms = terms | (gg[j] & prop);
        prop  = prop & gp[j];
      end
      gc[k] = terms | (cin & prop);
    end
  end

  assign sum   = p ^ c;
  assign cout  = gc[NG];
  assign c_msb = c[W-1];
endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Wide add/subtract that reuses one W-bit lookahead adder across NW words,
// least-significant word first, with the carry chained through a register.
module cla_serial_add_ctrl
  import cla_serial_pkg::*;
#(
  parameter int W  = 8,
  parameter int NW = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  cla_serial_add_ctrl_if.slave bus
);
  localparam int IW = idx_width(NW);

  state_e state_reg;
  state_e state_next;

  logic [NW-1:0][W-1:0] a_q;
  logic [NW-1:0][W-1:0] b_q;
  logic [NW-1:0][W-1:0] sum_q;
  logic [IW-1:0]        idx_q;
  logic                 carry_q;
  logic                 cout_q;
  logic                 ovf_q;

  logic [W-1:0] word_sum;
  logic         word_cout;
  logic         word_cmsb;
  logic         last_word;

  assign last_word = (idx_q == IW'(NW - 1));

  cla_word_adder #(.W(W)) u_word_adder (
    .a     (a_q[idx_q]),
    .b     (b_q[idx_q]),
    .cin   (carry_q),
    .sum   (word_sum),
    .cout  (word_cout),
    .c_msb (word_cmsb)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid_i) state_next = RUN;
      RUN:     if (last_word)      state_next = DONE;
      DONE:    if (bus.out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B on capture and force the carry-in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid_i) begin
            a_q     <= bus.a_i;
            b_q     <= bus.sub_i ? ~bus.b_i : bus.b_i;
            carry_q <= bus.sub_i ? 1'b1 : bus.cin_i;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[idx_q] <= word_sum;
          carry_q      <= word_cout;
          idx_q        <= idx_q + IW'(1);
          if (last_word) begin
            cout_q <= word_cout;
            ovf_q  <= word_cmsb ^ word_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o  = (state_reg == IDLE);
  assign bus.out_valid_o = (state_reg == DONE);
  assign bus.busy_o      = (state_reg != IDLE);
  assign bus.sum_o       = sum_q;
  assign bus.cout_o      = cout_q;
  assign bus.ovf_o       = ovf_q;
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed and randomized checks of the serial wide adder at W=8, NW=4.
// Outputs are sampled 1 time unit after the rising edge.
module tb_cla_serial_add_ctrl;
  localparam int W  = 8;
  localparam int NW = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  cla_serial_add_ctrl_if #(.W(W), .NW(NW)) bus_if ();

  cla_serial_add_ctrl #(.W(W), .NW(NW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, output logic [31:0] s, output logic c,
                       output logic o);
    logic [31:0] bb;
    logic [32:0] full;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    s    = full[31:0];
    c    = full[32];
    o    = (a[31] == bb[31]) && (s[31] != a[31]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for IDLE, submits one request, returns latency and results after stall cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input int stall, output logic [31:0] s,
                        output logic c, output logic o, output int lat);
    int n;
    n = 0;
    while (!bus_if.in_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!bus_if.in_ready_o) check("ready_timeout", 64'd0, 64'd1);
    bus_if.in_valid_i  = 1'b1;
    bus_if.a_i         = a;
    bus_if.b_i         = b;
    bus_if.cin_i       = cin;
    bus_if.sub_i       = sub;
    bus_if.out_ready_i = 1'b0;
    tick();
    bus_if.in_valid_i = 1'b0;
    lat = 0;
    while (!bus_if.out_valid_o && lat < 50) begin
      tick();
      lat++;
    end
    if (!bus_if.out_valid_o) check("valid_timeout", 64'd0, 64'd1);
    repeat (stall) tick();
    s = bus_if.sum_o;
    c = bus_if.cout_o;
    o = bus_if.ovf_o;
    bus_if.out_ready_i = 1'b1;
    tick();
    bus_if.out_ready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] s, ra, rb, es;
    logic        c, o, rc, rs, ec, eo;
    int          lat, n;

    n_tests = 0;
    n_fail  = 0;
    bus_if.in_valid_i  = 1'b0;
    bus_if.a_i         = '0;
    bus_if.b_i         = '0;
    bus_if.cin_i       = 1'b0;
    bus_if.sub_i       = 1'b0;
    bus_if.out_ready_i = 1'b0;

    rst = 1'b1;
    repeat (2) tick();
    check("rst_in_ready", 64'(bus_if.in_ready_o), 64'd1);
    check("rst_out_valid", 64'(bus_if.out_valid_o), 64'd0);
    check("rst_busy", 64'(bus_if.busy_o), 64'd0);
    check("rst_sum", 64'(bus_if.sum_o), 64'd0);
    check("rst_cout_ovf", 64'({bus_if.cout_o, bus_if.ovf_o}), 64'd0);
    rst = 1'b0;

    // 1: carry across the first word boundary, latency check
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, s, c, o, lat);
    check("t1_lat", 64'(lat), 64'd4);
    check("t1_sum", 64'(s), 64'h00000100);
    check("t1_cout_ovf", 64'({c, o}), 64'b00);
    check("t1_ready_after", 64'(bus_if.in_ready_o), 64'd1);

    // 2: carry ripples through all words
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0, s, c, o, lat);
    check("t2_sum", 64'(s), 64'h0);
    check("t2_cout_ovf", 64'({c, o}), 64'b10);

    // 3: signed overflow, then subtract with borrow
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, s, c, o, lat);
    check("t3a_sum", 64'(s), 64'h80000000);
    check("t3a_cout_ovf", 64'({c, o}), 64'b01);
    run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 2, s, c, o, lat);
    check("t3b_sum", 64'(s), 64'hFFFFFFFE);
    check("t3b_cout_ovf", 64'({c, o}), 64'b00);

    // 4: backpressure in DONE with new requests pulsing
    bus_if.in_valid_i  = 1'b1;
    bus_if.a_i         = 32'h00000011;
    bus_if.b_i         = 32'h00000022;
    bus_if.cin_i       = 1'b0;
    bus_if.sub_i       = 1'b0;
    bus_if.out_ready_i = 1'b0;
    tick();
    bus_if.in_valid_i = 1'b0;
    repeat (4) tick();
    check("t4_valid", 64'(bus_if.out_valid_o), 64'd1);
    for (int i = 0; i < 10; i++) begin
      bus_if.in_valid_i = i[0];
      bus_if.a_i        = 32'h00000100 + i;
      bus_if.b_i        = 32'h00000200;
      tick();
      check("t4_hold_sum", 64'(bus_if.sum_o), 64'h00000033);
      check("t4_hold_rdy_vld", 64'({bus_if.in_ready_o, bus_if.out_valid_o}), 64'b01);
    end
    bus_if.in_valid_i  = 1'b1;
    bus_if.a_i         = 32'h00001000;
    bus_if.b_i         = 32'h00000234;
    bus_if.out_ready_i = 1'b1;
    tick();
    bus_if.out_ready_i = 1'b0;
    check("t4_release_idle", 64'({bus_if.in_ready_o, bus_if.out_valid_o, bus_if.busy_o}), 64'b100);
    tick();
    bus_if.in_valid_i = 1'b0;
    check("t4_accept_busy", 64'({bus_if.in_ready_o, bus_if.busy_o}), 64'b01);
    repeat (4) tick();
    check("t4_pend_valid", 64'(bus_if.out_valid_o), 64'd1);
    check("t4_pend_sum", 64'(bus_if.sum_o), 64'h00001234);
    bus_if.out_ready_i = 1'b1;
    tick();
    bus_if.out_ready_i = 1'b0;

    // 5: reset while the third word is next
    bus_if.in_valid_i = 1'b1;
    bus_if.a_i        = 32'h01020304;
    bus_if.b_i        = 32'h10101010;
    tick();
    bus_if.in_valid_i = 1'b0;
    repeat (2) tick();
    check("t5_partial", 64'({bus_if.busy_o, bus_if.sum_o[15:0]}), 64'h11314);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_state", 64'({bus_if.in_ready_o, bus_if.out_valid_o, bus_if.busy_o}), 64'b100);
    check("t5_rst_sum", 64'(bus_if.sum_o), 64'h0);
    check("t5_rst_cout_ovf", 64'({bus_if.cout_o, bus_if.ovf_o}), 64'b00);
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 0, s, c, o, lat);
    check("t5_sum", 64'(s), 64'h23456789);
    check("t5_cout", 64'(c), 64'd0);

    // 6: randomized operands and stalls against the reference model
    for (n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if (n % 8 == 0) rb = ~ra;
      if (n % 8 == 1) rb = ra;
      model(ra, rb, rc, rs, es, ec, eo);
      run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), s, c, o, lat);
      check("rnd_lat", 64'(lat), 64'd4);
      check("rnd_sum", 64'(s), 64'(es));
      check("rnd_cout_ovf", 64'({c, o}), 64'({ec, eo}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_serial_add_ctrl.md
# cla_serial_add_ctrl

Multi-cycle wide-adder controller that time-shares one W-bit carry-lookahead word adder across NW words. It computes an (W·NW)-bit add or subtract one word per cycle, least-significant word first, and chains the carry through a register. It sits between a valid/ready requester and a consumer, and is used where a full-width CLA costs too much area.

## Interface
- `W`, 8: word width per pass. Must be a multiple of 4 and ≥ 4.
- `NW`, 4: number of words. Must be ≥ 1. Operand width is W·NW.
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `in_valid_i` input 1: request valid.
- `in_ready_o` output 1: controller can accept a request.
- `a_i` input W·NW: operand A.
- `b_i` input W·NW: operand B.
- `cin_i` input 1: carry-in. Ignored when `sub_i`=1.
- `sub_i` input 1: 1 selects A − B, 0 selects A + B + cin.
- `out_valid_o` output 1: result valid.
- `out_ready_i` input 1: consumer accepts the result.
- `sum_o` output W·NW: result.
- `cout_o` output 1: carry out of the MSB. In subtract mode, 1 means no borrow.
- `ovf_o` output 1: signed overflow, equal to carry into MSB XOR carry out of MSB.
- `busy_o` output 1: state ≠ IDLE.

## Operation
- **States:**
  - IDLE: `in_ready_o`=1.
  - RUN: one word per edge.
  - DONE: `out_valid_o`=1.
- **Acceptance.** Occurs on `in_valid_i & in_ready_o` in IDLE. On that edge:
  - latch A into `a_q`;
  - latch B into `b_q`, as ~B if `sub_i`, else B;
  - set `carry_q` = `sub_i` ? 1 : `cin_i`;
  - set `idx_q` = 0;
  - go to RUN.
- **RUN edge.**
  - Word adder inputs: `a_q[idx]`, `b_q[idx]`, `carry_q`.
  - Write the word sum into `sum_q[idx]`.
  - Set `carry_q` to the word carry-out and `idx_q` to idx+1.
  - When idx = NW−1: also latch `cout_q` = word carry-out and `ovf_q` = c_msb XOR carry-out, then go to DONE.
- **DONE.**
  - `sum_o`, `cout_o` and `ovf_o` are held stable while `out_ready_i`=0.
  - On `out_ready_i`=1, go to IDLE.
- **No pipelining.** `in_ready_o`=0 in RUN and DONE. `in_valid_i` is ignored there and requests are not queued.
- **Outputs outside DONE.** `sum_o` shows partially written words during RUN. It is meaningful only while `out_valid_o`=1, and retains the last value in IDLE.
- **Arithmetic.** Everything is modulo 2^(W·NW). `idx_q` width is max(1, $clog2(NW)).
- **NW=1.** RUN lasts exactly one edge.

## Timing
- **Reset** (any state, including mid-RUN): next cycle state is IDLE, with:
  - `in_ready_o`=1;
  - `out_valid_o`=0, `busy_o`=0;
  - `sum_o`=0, `cout_o`=0, `ovf_o`=0;
  - `carry_q`=0, `idx_q`=0.

  Any in-flight operation is discarded.
- **Latency.** Acceptance on edge t0 puts `out_valid_o`=1 from edge t0+NW.
- **Handshake release.** A result handshake on edge t1 puts `in_ready_o`=1 from edge t1.
- **Throughput.** The next acceptance is no earlier than edge t1+1, so the minimum period is NW+2 cycles.
- **Combinational outputs.** `in_ready_o`, `out_valid_o` and `busy_o` are decoded from the state register only, with no combinational path from inputs.
- **Register boundary.** The word adder is the only combinational arithmetic path and runs register-to-register in one cycle.

## Structure
- Package `cla_serial_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} state_e`;
  - width helper constant for `idx_q`.
- Sub-module `cla_word_adder` #(W):
  - inputs a, b, cin; outputs sum[W], cout, c_msb (carry into bit W−1);
  - built from W/4 4-bit lookahead groups with a group-level P/G lookahead across groups;
  - purely combinational.
- The top level holds the FSM, the operand, sum and carry registers, and the word mux/demux.

## Test plan
All scenarios use W=8, NW=4.
1. 0x000000FF + 0x00000001, cin 0 → `sum_o`=0x00000100, `cout_o`=0, `ovf_o`=0; `out_valid_o` rises exactly 4 edges after acceptance.
2. 0xFFFFFFFF + 0x00000000, cin 1 → `sum_o`=0, `cout_o`=1, `ovf_o`=0. This checks carry ripple through all 4 words.
3. 0x7FFFFFFF + 0x00000001 → `sum_o`=0x80000000, `cout_o`=0, `ovf_o`=1. Then sub 0x00000005 − 0x00000007 → `sum_o`=0xFFFFFFFE, `cout_o`=0, `ovf_o`=0.
4. Backpressure: hold `out_ready_i`=0 for 10 cycles in DONE while pulsing `in_valid_i` with new operands → outputs stable, `in_ready_o`=0, no new acceptance. Raise `out_ready_i` → IDLE the next cycle and the pending request is accepted one edge later.
5. Reset at RUN with idx=2 → next cycle IDLE, all outputs 0, `in_ready_o`=1. A following 0x12345678 + 0x11111111 → 0x23456789, `cout_o`=0.
6. Random: 1000 random A, B, cin and sub operations with random `out_ready_i` stalls, checked against a reference model on every handshake.
